// File: rtl/radix2_divider.sv
// Multi-cycle restoring radix-2 divider: one quotient bit per cycle, DIV/DIVU/REM/REMU.
// Define RADIX2_DIVIDER_FASTPATH_EN to finish divide-by-zero and signed overflow on the accepting edge.
module radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef RADIX2_DIVIDER_FASTPATH_EN
  localparam logic FASTPATH = 1'b1;
`else
  localparam logic FASTPATH = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_dividend;
  logic               r_is_rem;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_div0;
  logic [WIDTH-1:0]   r_result;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div0;
  logic               w_ovf;
  logic               w_accept;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_result;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_nxt;
  logic               w_last;
  logic [WIDTH-1:0]   w_q_final;
  logic [WIDTH-1:0]   w_r_final;

  // Operand conditioning: only op_i[0] = 0 selects signed handling.
  assign w_signed = ~op_i[0];
  assign w_a_neg  = w_signed & dividend_i[WIDTH-1];
  assign w_b_neg  = w_signed & divisor_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_mag  = w_b_neg ? -divisor_i  : divisor_i;
  assign w_div0   = (divisor_i == '0);
  assign w_ovf    = w_signed && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
  assign w_accept = valid_i && (r_state == S_IDLE);
  assign w_fast   = FASTPATH && (w_div0 || w_ovf);

  always_comb begin
    if (w_div0) w_fast_result = op_i[1] ? dividend_i : '1;
    else        w_fast_result = op_i[1] ? '0 : dividend_i;
  end

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_rem_nxt  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};
  assign w_last     = (r_state == S_CALC) && (r_count == CNT_W'(WIDTH - 1));

  // Divide-by-zero overrides the magnitude result, whose sign correction would be wrong there.
  assign w_q_final = r_div0 ? '1         : (r_q_neg ? -w_quot_nxt : w_quot_nxt);
  assign w_r_final = r_div0 ? r_dividend : (r_r_neg ? -w_rem_nxt  : w_rem_nxt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next-state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (valid_i) w_state_nxt = w_fast ? S_DONE : S_CALC;
      S_CALC: if (w_last)  w_state_nxt = S_DONE;
      S_DONE: if (ready_i) w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_is_rem   <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div0     <= 1'b0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_count    <= '0;
      r_quot     <= w_a_mag;
      r_rem      <= '0;
      r_divisor  <= w_b_mag;
      r_dividend <= dividend_i;
      r_is_rem   <= op_i[1];
      r_q_neg    <= w_a_neg ^ w_b_neg;
      r_r_neg    <= w_a_neg;
      r_div0     <= w_div0;
      if (w_fast) r_result <= w_fast_result;
    end else if (r_state == S_CALC) begin
      r_count <= r_count + CNT_W'(1);
      r_quot  <= w_quot_nxt;
      r_rem   <= w_rem_nxt;
      if (w_last) r_result <= r_is_rem ? w_r_final : w_q_final;
    end else if (r_state == S_DONE && ready_i) begin
      r_result <= '0;
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;

endmodule
